// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD dot-product/ReLU sequencer.
// relu_sat converts a raw accumulator into the clamped, non-negative result.
package simd_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned FRAC   = 8;
   localparam int unsigned ACC_W  = 40;
   localparam int unsigned ADDR_W = 8;

   localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((64'(1) << (DATA_W - 1)) - 64'(1));

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      OUTPUT
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sat;
   } res_t;

   // Scale by FRAC, clamp negatives to zero and large positives to max.
   function automatic res_t relu_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] s;
      res_t                    r;
      s = acc >>> FRAC;
      r = '0;
      if (s[ACC_W-1]) begin
         r = '0;
      end else if (s > RES_MAX) begin
         r.data = DATA_W'(RES_MAX);
         r.sat  = 1'b1;
      end else begin
         r.data = s[DATA_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/simd_lane_mac.sv
// Combinational LANES-wide signed multiply with a sign-extended lane sum.
module simd_lane_mac #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 40
) (
   input  logic        [LANES*DATA_W-1:0] a,
   input  logic        [LANES*DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]        sum_c
);

   logic signed [2*DATA_W-1:0] prod [LANES];

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         prod[i] = $signed(a[i*DATA_W +: DATA_W]) * $signed(b[i*DATA_W +: DATA_W]);
         sum_c   = sum_c + $signed({{(ACC_W - 2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]});
      end
   end

endmodule

// File: rtl/simd_dot_seq_ctrl.sv
// Sequencer: streams LEN operand words from the buffer, accumulates lane dot
// products and presents one ReLU'd, saturated result on a valid/ready port.
module simd_dot_seq_ctrl
   import simd_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [ADDR_W-1:0]       len,
   output logic                    busy,
   output logic                    rd_en,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic [LANES*DATA_W-1:0] rd_data_a,
   input  logic [LANES*DATA_W-1:0] rd_data_b,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [DATA_W-1:0]       res_data,
   output logic                    res_sat
);

   state_e                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
   logic                    rd_vld_q, rd_vld_d;
   logic [ADDR_W-1:0]       ptr_q, ptr_d;
   logic [ADDR_W-1:0]       cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    res_valid_q, res_valid_d;
   logic [DATA_W-1:0]       res_data_q, res_data_d;
   logic                    res_sat_q, res_sat_d;
   logic signed [ACC_W-1:0] lane_sum_c;
   res_t                    relu_r;

   simd_lane_mac #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .a     (rd_data_a),
      .b     (rd_data_b),
      .sum_c (lane_sum_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_vld_q    <= 1'b0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         rd_vld_q    <= rd_vld_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_sat_q   <= res_sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (len != '0) ? FETCH : OUTPUT;
         FETCH:   if (cnt_q == ADDR_W'(1)) state_d = DRAIN;
         DRAIN:   state_d = OUTPUT;
         OUTPUT:  if (res_valid_q && res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read data lands one cycle after rd_en, so accumulation trails the strobe by one.
   always_comb begin
      busy_d      = busy_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      rd_vld_d    = rd_en_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      acc_d       = rd_vld_q ? (acc_q + lane_sum_c) : acc_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_sat_d   = res_sat_q;
      relu_r      = relu_sat(acc_d);
      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               ptr_d  = base_addr;
               cnt_d  = len;
               acc_d  = '0;
            end
         end
         FETCH: begin
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_q;
            ptr_d     = ptr_q + ADDR_W'(1);
            cnt_d     = cnt_q - ADDR_W'(1);
         end
         OUTPUT: begin
            if (!res_valid_q) begin
               res_valid_d = 1'b1;
               res_data_d  = relu_r.data;
               res_sat_d   = relu_r.sat;
            end else if (res_ready) begin
               res_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign busy      = busy_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_sat   = res_sat_q;

endmodule

// File: tb/tb_simd_dot_seq_ctrl.sv
// Self-checking bench: operand memory model, directed cases and randomized
// operations compared against an arithmetic reference of the dot/ReLU result.
module tb_simd_dot_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  len;
   logic        busy;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [63:0] rd_data_a;
   logic [63:0] rd_data_b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_sat;

   logic [63:0] mem_a [256];
   logic [63:0] mem_b [256];
   int          rd_log [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   simd_dot_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_sat   (res_sat)
   );

   always #5 clk = ~clk;

   // Operand buffer: one-cycle read latency, junk on idle cycles.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= mem_a[rd_addr];
         rd_data_b <= mem_b[rd_addr];
         rd_log.push_back(int'(rd_addr));
      end else begin
         rd_data_a <= {$urandom, $urandom};
         rd_data_b <= {$urandom, $urandom};
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: plain integer dot product over the addressed words.
   task automatic model(input int base, input int n, output longint data, output longint sat);
      longint      acc;
      longint      s;
      logic [63:0] wa, wb;
      logic signed [15:0] ea, eb;
      acc = 0;
      for (int k = 0; k < n; k++) begin
         wa = mem_a[(base + k) % 256];
         wb = mem_b[(base + k) % 256];
         for (int l = 0; l < 4; l++) begin
            ea = wa[l*16 +: 16];
            eb = wb[l*16 +: 16];
            acc += longint'(ea) * longint'(eb);
         end
      end
      s = acc >>> 8;
      if (s < 0) begin data = 0; sat = 0; end
      else if (s > 32767) begin data = 32767; sat = 1; end
      else begin data = s; sat = 0; end
   endtask

   task automatic fill(input int base, input int n, input logic [63:0] wa, input logic [63:0] wb);
      for (int k = 0; k < n; k++) begin
         mem_a[(base + k) % 256] = wa;
         mem_b[(base + k) % 256] = wb;
      end
   endtask

   function automatic logic [63:0] rnd_word(input int mode);
      logic [63:0] w;
      for (int l = 0; l < 4; l++) begin
         case (mode)
            0:       w[l*16 +: 16] = 16'($urandom);
            1:       w[l*16 +: 16] = 16'($urandom_range(0, 1023)) - 16'(512);
            default: w[l*16 +: 16] = 16'($urandom_range(0, 400));
         endcase
      end
      return w;
   endfunction

   task automatic run_op(input int base, input int n, input int hold, input bit poke);
      longint exp_d, exp_s;
      int     lat;
      bit     found;
      model(base, n, exp_d, exp_s);
      rd_log.delete();
      @(negedge clk);
      start = 1'b1; base_addr = 8'(base); len = 8'(n);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", longint'(busy), 1);
      lat = 0; found = 1'b0;
      for (int i = 1; i <= n + 8; i++) begin
         @(posedge clk); #1;
         if (res_valid) begin lat = i; found = 1'b1; break; end
      end
      check("res_valid_seen", longint'(found), 1);
      if (!found) return;
      check("latency", longint'(lat), (n == 0) ? 1 : n + 2);
      check("res_data", longint'(res_data), exp_d);
      check("res_sat", longint'(res_sat), exp_s);
      check("rd_count", longint'(rd_log.size()), longint'(n));
      if (rd_log.size() == n)
         for (int k = 0; k < n; k++)
            check($sformatf("rd_addr%0d", k), longint'(rd_log[k]), longint'((base + k) % 256));
      for (int i = 0; i < hold; i++) begin
         start = poke && (i == 1);
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (hold > 0) begin
         check("hold_valid", longint'(res_valid), 1);
         check("hold_busy", longint'(busy), 1);
         check("hold_data", longint'(res_data), exp_d);
         check("hold_sat", longint'(res_sat), exp_s);
      end
      res_ready = 1'b1;
      start = poke;
      @(posedge clk); #1;
      res_ready = 1'b0;
      start = 1'b0;
      check("post_hs_valid", longint'(res_valid), 0);
      check("post_hs_busy", longint'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", longint'(busy), 0);
      check("idle_no_reads", longint'(rd_log.size()), longint'(n));
      if (n > 0) check("rd_addr_hold", longint'(rd_addr), longint'((base + n - 1) % 256));
   endtask

   initial begin
      int   base, n, mode;
      int   logged;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; res_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", longint'(busy), 0);
      check("rst_rd_en", longint'(rd_en), 0);
      check("rst_rd_addr", longint'(rd_addr), 0);
      check("rst_valid", longint'(res_valid), 0);
      check("rst_data", longint'(res_data), 0);
      check("rst_sat", longint'(res_sat), 0);
      @(negedge clk) rst_n = 1'b1;

      fill(8'h10, 1, {4{16'h0100}}, {4{16'h0100}});
      run_op(8'h10, 1, 0, 1'b0);
      fill(8'h20, 2, {4{16'h0100}}, {4{16'hFF00}});
      run_op(8'h20, 2, 1, 1'b0);
      fill(8'h30, 4, {4{16'h7FFF}}, {4{16'h7FFF}});
      run_op(8'h30, 4, 0, 1'b0);
      run_op(8'h40, 0, 2, 1'b0);
      for (int k = 0; k < 4; k++) fill((8'hFE + k) % 256, 1, rnd_word(2), rnd_word(2));
      run_op(8'hFE, 4, 5, 1'b1);

      // Abort mid-fetch with an asynchronous reset.
      fill(8'h50, 8, {4{16'h0100}}, {4{16'h0100}});
      @(negedge clk);
      start = 1'b1; base_addr = 8'h50; len = 8'd8;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("pre_abort_rd_en", longint'(rd_en), 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", longint'(busy), 0);
      check("abort_rd_en", longint'(rd_en), 0);
      check("abort_rd_addr", longint'(rd_addr), 0);
      check("abort_valid", longint'(res_valid), 0);
      logged = rd_log.size();
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_reads", longint'(rd_log.size()), longint'(logged));
      check("abort_no_valid", longint'(res_valid), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("after_abort_idle", longint'(busy), 0);
      fill(8'h60, 1, {4{16'h0100}}, {4{16'h0100}});
      run_op(8'h60, 1, 0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         base = $urandom_range(0, 255);
         n    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
         mode = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) fill((base + k) % 256, 1, rnd_word(mode), rnd_word(mode));
         run_op(base, n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
